// File: rtl/sm_para_ctrl_pkg.sv
// sm_para_ctrl_pkg: shared definitions for the paragraph-FSM sequencer.
// State encodings (4-bit binary), fail codes, expected monitor codes and
// the Moore drive-pattern decode.
package sm_para_ctrl_pkg;

  typedef enum logic [3:0] {
    StCIdle   = 4'd0,
    StS1Step  = 4'd1,
    StS1Chk   = 4'd2,
    StS2Step  = 4'd3,
    StS2Chk   = 4'd4,
    StIdStep  = 4'd5,
    StIdChk   = 4'd6,
    StRecover = 4'd7,
    StDone    = 4'd8
  } ctrl_state_e;

  // fail_code values
  localparam logic [1:0] FC_OK       = 2'b00;
  localparam logic [1:0] FC_NOT_IDLE = 2'b01;
  localparam logic [1:0] FC_ERR      = 2'b10;
  localparam logic [1:0] FC_TMO      = 2'b11;

  // Expected {o1,o2,err} per FSM state
  localparam logic [2:0] MON_IDLE = 3'b000;
  localparam logic [2:0] MON_S1   = 3'b100;
  localparam logic [2:0] MON_S2   = 3'b010;
  localparam logic [2:0] MON_ERR  = 3'b111;

  // {i1,i2} applied to the FSM in each sequencer state; CHK patterns hold the FSM still
  function automatic logic [1:0] drive_pattern(ctrl_state_e st);
    logic [1:0] pat;
    pat = 2'b00;
    case (st)
      StS1Step: pat = 2'b11;
      StS2Step: pat = 2'b11;
      StS2Chk:  pat = 2'b01;
      StIdStep: pat = 2'b10;
      default:  pat = 2'b00;
    endcase
    return pat;
  endfunction

  // States in which the sequencer waits on the FSM
  function automatic logic is_wait_state(ctrl_state_e st);
    return (st == StS1Chk) || (st == StS2Chk) || (st == StIdChk) || (st == StRecover);
  endfunction

endpackage

// File: rtl/sm_para_ctrl_tmo.sv
// sm_para_ctrl_tmo: wait counter for CHK/RECOVER states.
// clr marks the first cycle in a wait state; expired is high in the TMO-th cycle spent there.
module sm_para_ctrl_tmo #(
  parameter int unsigned TMO = 8
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TMO + 1);

  // Cycles already spent in the current wait state before this one
  logic [CW-1:0] cnt_q;

  // Count time in state; first cycle reloads so the next cycle sees one elapsed
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= CW'(1);
    end else if (en && !expired) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Expire on the TMO-th cycle in state, including the entry cycle when TMO is 1
  always_comb begin
    expired = 1'b0;
    if (en) begin
      if (clr) expired = (TMO == 1);
      else     expired = (cnt_q >= CW'(TMO - 1));
    end
  end

endmodule

// File: rtl/sm_para_ctrl.sv
// sm_para_ctrl: walks the paragraph FSM through IDLE->S1->S2->IDLE laps,
// recovers it from ERROR and reports a status code with a done pulse.
// Optional wait timeout is enabled by defining SM_PARA_CTRL_TMO_EN.
module sm_para_ctrl
  import sm_para_ctrl_pkg::*;
#(
  parameter int unsigned LAP_W = 4,
  parameter int unsigned TMO   = 8
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [LAP_W-1:0] lap_num,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fail_code,
  output logic [LAP_W-1:0] lap_cnt,
  output logic             drv_i1,
  output logic             drv_i2,
  input  logic             mon_o1,
  input  logic             mon_o2,
  input  logic             mon_err
);

  if (TMO == 0) begin : g_tmo_invalid
    $error("TMO must be at least 1");
  end

  logic [2:0]       mon;
  ctrl_state_e      state_q;
  logic [LAP_W-1:0] lap_num_q;
  logic [LAP_W-1:0] lap_inc;
  logic             tmo_expired;

  assign mon = {mon_o1, mon_o2, mon_err};

  // Saturating lap increment
  always_comb begin
    lap_inc = (&lap_cnt) ? lap_cnt : lap_cnt + LAP_W'(1);
  end

`ifdef SM_PARA_CTRL_TMO_EN
  ctrl_state_e prev_q;

  // Previous state, to spot the entry cycle of each wait state
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) prev_q <= StCIdle;
    else       prev_q <= state_q;
  end

  sm_para_ctrl_tmo #(
    .TMO(TMO)
  ) u_tmo (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (state_q != prev_q),
    .en      (is_wait_state(state_q)),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  // Sequencer FSM with registered lap count and status
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StCIdle;
      lap_num_q <= '0;
      lap_cnt   <= '0;
      fail_code <= FC_OK;
    end else begin
      case (state_q)
        StCIdle: begin
          if (start) begin
            lap_num_q <= lap_num;
            lap_cnt   <= '0;
            fail_code <= FC_OK;
            if (lap_num == '0) begin
              state_q <= StDone;
            end else if (mon != MON_IDLE) begin
              state_q   <= StDone;
              fail_code <= FC_NOT_IDLE;
            end else begin
              state_q <= StS1Step;
            end
          end
        end
        StS1Step: state_q <= StS1Chk;
        StS2Step: state_q <= StS2Chk;
        StIdStep: state_q <= StIdChk;
        StS1Chk: begin
          if (mon_err) begin
            state_q <= StRecover;
          end else if (mon == MON_S1) begin
            state_q <= StS2Step;
          end else if (tmo_expired) begin
            state_q   <= StDone;
            fail_code <= FC_TMO;
          end
        end
        StS2Chk: begin
          if (mon_err) begin
            state_q <= StRecover;
          end else if (mon == MON_S2) begin
            state_q <= StIdStep;
          end else if (tmo_expired) begin
            state_q   <= StDone;
            fail_code <= FC_TMO;
          end
        end
        StIdChk: begin
          if (mon_err) begin
            state_q <= StRecover;
          end else if (mon == MON_IDLE) begin
            lap_cnt <= lap_inc;
            if (lap_inc == lap_num_q) begin
              state_q   <= StDone;
              fail_code <= FC_OK;
            end else begin
              state_q <= StS1Step;
            end
          end else if (tmo_expired) begin
            state_q   <= StDone;
            fail_code <= FC_TMO;
          end
        end
        StRecover: begin
          if (mon == MON_IDLE) begin
            state_q   <= StDone;
            fail_code <= FC_ERR;
          end else if (tmo_expired) begin
            state_q   <= StDone;
            fail_code <= FC_TMO;
          end
        end
        StDone:  state_q <= StCIdle;
        default: state_q <= StCIdle;
      endcase
    end
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    busy             = (state_q != StCIdle);
    done             = (state_q == StDone);
    {drv_i1, drv_i2} = drive_pattern(state_q);
  end

endmodule
